// File: rtl/booth_mult_arbiter_if.sv
// Requester/core bundle around the shared Booth multiplier arbiter.
// The arbiter connects through the slave modport; requesters and the core sit on master.
interface booth_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
);
  logic        [NUM_REQ-1:0]       req;
  logic        [NUM_REQ*WIDTH-1:0] req_a;
  logic        [NUM_REQ*WIDTH-1:0] req_b;
  logic        [NUM_REQ-1:0]       gnt;
  logic        [NUM_REQ-1:0]       rsp_valid;
  logic signed [2*WIDTH-1:0]       rsp_result;
  logic                            rsp_err;
  logic                            busy;
  logic                            mult_op_start;
  logic signed [WIDTH-1:0]         mult_a;
  logic signed [WIDTH-1:0]         mult_b;
  logic                            mult_op_done;
  logic signed [2*WIDTH-1:0]       mult_result;

  modport master (
    output req, req_a, req_b, mult_op_done, mult_result,
    input  gnt, rsp_valid, rsp_result, rsp_err, busy, mult_op_start, mult_a, mult_b
  );

  modport slave (
    input  req, req_a, req_b, mult_op_done, mult_result,
    output gnt, rsp_valid, rsp_result, rsp_err, busy, mult_op_start, mult_a, mult_b
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one sequential Booth multiplier core between NUM_REQ requesters,
// with a watchdog that turns a missing op_done into an error response.
module booth_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 80
) (
  input  logic                clk,
  input  logic                reset,
  booth_mult_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nx;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [7:0]         wd_cnt;
  logic               wd_expired;
  int                 idx;

  assign wd_expired = (wd_cnt == 8'(TIMEOUT - 1));

  // Search ptr, ptr+1, ... downwards so the closest requester to ptr is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[PTR_W'(idx)]) begin
        winner = PTR_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // op_done is not looked at in START: the core still shows the previous operation's flag.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (bus.mult_op_done || wd_expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt = '0;
    if (state == IDLE && found && !reset) bus.gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr               <= '0;
      owner             <= '0;
      wd_cnt            <= '0;
      bus.mult_a        <= '0;
      bus.mult_b        <= '0;
      bus.rsp_result    <= '0;
      bus.rsp_err       <= 1'b0;
      bus.rsp_valid     <= '0;
      bus.busy          <= 1'b0;
      bus.mult_op_start <= 1'b0;
    end else begin
      bus.mult_op_start <= (state_nx == START);
      bus.busy          <= (state_nx != IDLE);
      bus.rsp_valid     <= '0;
      case (state)
        IDLE: if (found) begin
          owner      <= winner;
          bus.mult_a <= bus.req_a[int'(winner)*WIDTH +: WIDTH];
          bus.mult_b <= bus.req_b[int'(winner)*WIDTH +: WIDTH];
        end
        START: wd_cnt <= '0;
        WAIT: begin
          if (bus.mult_op_done) begin
            bus.rsp_result <= bus.mult_result;
            bus.rsp_err    <= 1'b0;
            bus.rsp_valid  <= NUM_REQ'(1) << owner;
          end else if (wd_expired) begin
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= NUM_REQ'(1) << owner;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP: ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized bench for booth_mult_arbiter: transaction-level reference model plus a
// behavioural multiplier core with programmable done latency.
module tb_booth_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 80;
  localparam int PW      = 2 * WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  booth_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  booth_mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [PW-1:0] prod(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  // Behavioural core: done is a level that clears on op_start and rises core_lat WAIT cycles later.
  logic                 core_done = 1'b0;
  logic signed [PW-1:0] core_res  = '0;
  int                   core_lat  = 0;
  int                   core_cnt  = 0;
  bit                   core_act  = 1'b0;
  assign bus.mult_op_done = core_done;
  assign bus.mult_result  = core_res;

  always @(posedge clk) begin
    if (bus.mult_op_start === 1'b1) begin
      core_cnt  <= 0;
      core_act  <= (core_lat != 0);
      core_done <= (core_lat == 0);
      core_res  <= prod(bus.mult_a, bus.mult_b);
    end else if (core_act) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == core_lat) begin
        core_done <= 1'b1;
        core_act  <= 1'b0;
      end
    end
  end

  // Requesters
  bit                      pend [NUM_REQ];
  bit                      clr  [NUM_REQ];
  logic signed [WIDTH-1:0] a_v  [NUM_REQ];
  logic signed [WIDTH-1:0] b_v  [NUM_REQ];
  logic [NUM_REQ-1:0]      en   = '0;
  int                      prob = 0;

  // Reference model
  bit                      m_op = 1'b0;
  int                      m_owner, m_ptr = 0, m_gcyc, m_rcyc;
  logic signed [WIDTH-1:0] m_a, m_b;
  bit                      m_err;
  int                      forced_lat = -1;
  bit                      rand_long  = 1'b0;
  int                      glog [$];

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]                   = pend[i];
      bus.req_a[i*WIDTH +: WIDTH]  = a_v[i];
      bus.req_b[i*WIDTH +: WIDTH]  = b_v[i];
    end
  endtask

  task automatic stim();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clr[i]) begin
        pend[i] = 1'b0;
        clr[i]  = 1'b0;
      end
      if (!pend[i] && en[i] && $urandom_range(0, 99) < prob) begin
        pend[i] = 1'b1;
        a_v[i]  = WIDTH'({$urandom(), $urandom()});
        b_v[i]  = WIDTH'({$urandom(), $urandom()});
      end
    end
    drive();
  endtask

  task automatic post(input int i, input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    pend[i] = 1'b1;
    a_v[i]  = a;
    b_v[i]  = b;
    drive();
  endtask

  task automatic observe();
    logic [NUM_REQ-1:0] exp_gnt, exp_vld;
    int w, lat, eff;
    cyc++;
    exp_gnt = '0;
    exp_vld = '0;
    if (!m_op) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (w < 0 && bus.req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
      if (w >= 0) begin
        exp_gnt[w] = 1'b1;
        if (forced_lat >= 0) lat = forced_lat;
        else if (rand_long && $urandom_range(0, 9) == 0) lat = 1000;
        else lat = $urandom_range(0, 12);
        core_lat = lat;
        eff      = (lat > TIMEOUT - 1) ? TIMEOUT - 1 : lat;
        m_op     = 1'b1;
        m_owner  = w;
        m_a      = a_v[w];
        m_b      = b_v[w];
        m_err    = (lat > TIMEOUT - 1);
        m_gcyc   = cyc;
        m_rcyc   = cyc + 3 + eff;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.gnt[i] === 1'b1) begin
        glog.push_back(i);
        clr[i] = 1'b1;
      end
    chk("gnt", bus.gnt, exp_gnt);
    chk("op_start", bus.mult_op_start, m_op && cyc == m_gcyc + 1);
    chk("busy", bus.busy, m_op && cyc > m_gcyc);
    if (m_op && cyc == m_gcyc + 1) begin
      chk("mult_a", bus.mult_a, m_a);
      chk("mult_b", bus.mult_b, m_b);
    end
    if (m_op && cyc == m_rcyc) begin
      exp_vld[m_owner] = 1'b1;
      chk("rsp_result", bus.rsp_result, m_err ? '0 : prod(m_a, m_b));
      chk("rsp_err", bus.rsp_err, m_err);
      chk("mult_a_hold", bus.mult_a, m_a);
    end
    chk("rsp_valid", bus.rsp_valid, exp_vld);
    if (m_op && cyc == m_rcyc) begin
      m_op  = 1'b0;
      m_ptr = (m_owner + 1) % NUM_REQ;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      stim();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && m_op; i++) run(1);
    chk(tag, m_op, 1'b0);
  endtask

  task automatic quiesce();
    en = '0;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    drive();
    wait_idle("drain");
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mult_a", bus.mult_a, '0);
    chk("rst_mult_b", bus.mult_b, '0);
    chk("rst_result", bus.rsp_result, '0);
    chk("rst_err", bus.rsp_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_start", bus.mult_op_start, 1'b0);
    chk("rst_valid", bus.rsp_valid, '0);
    chk("rst_gnt", bus.gnt, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_op  = 1'b0;
    m_ptr = 0;
    chk_reset_outputs();
  endtask

  function automatic int gl(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      clr[i]  = 1'b0;
      a_v[i]  = '0;
      b_v[i]  = '0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;

    // Single request from requester 1: 3 * -5 with done after 64 WAIT cycles
    forced_lat = 64;
    post(1, 64'sd3, -64'sd5);
    run(1);
    chk("single_owner", gl(0), 1);
    wait_idle("single_done");
    run(2);

    // All four requesting continuously from reset
    do_reset();
    glog.delete();
    forced_lat = -1;
    en = '1;
    prob = 100;
    run(80);
    chk("order0", gl(0), 0);
    chk("order1", gl(1), 1);
    chk("order2", gl(2), 2);
    chk("order3", gl(3), 3);
    chk("order4", gl(4), 0);
    quiesce();

    // Requesters 2 and 3 only, ptr=3 after serving 2
    forced_lat = 4;
    post(2, WIDTH'($urandom()), WIDTH'($urandom()));
    run(1);
    wait_idle("rr23_first");
    glog.delete();
    post(2, -64'sd7, 64'sd9);
    post(3, 64'sd11, -64'sd13);
    run(1);
    wait_idle("rr23_second");
    run(1);
    wait_idle("rr23_third");
    chk("rr23_a", gl(0), 3);
    chk("rr23_b", gl(1), 2);

    // Core never answers, then a normal request
    forced_lat = 1000;
    post(0, WIDTH'({$urandom(), $urandom()}), WIDTH'({$urandom(), $urandom()}));
    run(1);
    wait_idle("timeout");
    forced_lat = 5;
    post(1, WIDTH'({$urandom(), $urandom()}), WIDTH'({$urandom(), $urandom()}));
    run(1);
    wait_idle("after_timeout");

    // Done on the last watchdog cycle wins; one cycle later is a timeout
    forced_lat = TIMEOUT - 1;
    post(2, -64'sd1, -64'sd1);
    run(1);
    wait_idle("edge_done");
    forced_lat = TIMEOUT;
    post(3, 64'sd2, 64'sd2);
    run(1);
    wait_idle("edge_timeout");

    // Random contention
    forced_lat = -1;
    rand_long  = 1'b1;
    en   = '1;
    prob = 30;
    run(600);
    quiesce();
    rand_long = 1'b0;

    // Reset in the middle of WAIT
    forced_lat = 3;
    post(1, 64'sd5, 64'sd6);
    run(1);
    wait_idle("pre_reset");
    forced_lat = 30;
    post(2, 64'sd8, 64'sd9);
    run(9);
    do_reset();
    run(40);
    glog.delete();
    forced_lat = 2;
    for (int i = 0; i < NUM_REQ; i++) post(i, WIDTH'($urandom()), WIDTH'($urandom()));
    run(1);
    chk("post_reset_winner", gl(0), 0);
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
